// File: rtl/wb_mem_slave_ws.sv
// Wishbone classic slave in front of an asynchronous SRAM-style memory.
// Address decode, latched access parameters, programmable wait states, registered ack.
module wb_mem_slave_ws #(
    parameter int unsigned           ADR_W   = 16,
    parameter int unsigned           DEC_W   = 4,
    parameter logic [DEC_W-1:0]      BASE    = '0,
    parameter int unsigned           DAT_W   = 8,
    parameter int unsigned           WAIT_RD = 2,
    parameter int unsigned           WAIT_WR = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADR_W-1:0]         adr_i,
    input  logic                     we_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    input  logic [DAT_W-1:0]         dat_i,
    output logic [DAT_W-1:0]         dat_o,
    output logic                     ack_o,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic                     mem_oe,
    output logic [ADR_W-DEC_W-1:0]   mem_dir,
    output logic [DAT_W-1:0]         mem_indata,
    input  logic [DAT_W-1:0]         mem_outdata
);

    localparam int unsigned MEM_W = ADR_W - DEC_W;
    localparam logic [3:0] WaitRd = 4'(WAIT_RD);
    localparam logic [3:0] WaitWr = 4'(WAIT_WR);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic [DAT_W-1:0]   dat_q;
    logic [MEM_W-1:0]   dir_q;
    logic [DAT_W-1:0]   indata_q;
    logic               bus_req;
    logic               sel;

    assign bus_req = cyc_i & stb_i;
    assign sel     = bus_req & (adr_i[ADR_W-1 -: DEC_W] == BASE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (sel) state_d = StWait;
            // A dropped strobe or cycle abandons the access without an ack.
            StWait: begin
                if (!bus_req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_cs = (state_q == StWait);
        mem_we = mem_cs & we_q;
        mem_oe = mem_cs & ~we_q;
        ack_o  = (state_q == StAck) & bus_req;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            dat_q    <= '0;
            dir_q    <= '0;
            indata_q <= '0;
        end else if (state_q == StIdle && sel) begin
            dir_q    <= adr_i[MEM_W-1:0];
            indata_q <= dat_i;
            we_q     <= we_i;
            cnt_q    <= we_i ? WaitWr : WaitRd;
        end else if (state_q == StWait) begin
            if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else if (bus_req && !we_q) begin
                dat_q <= mem_outdata;
            end
        end
    end

    assign dat_o      = dat_q;
    assign mem_dir    = dir_q;
    assign mem_indata = indata_q;

endmodule
